prng_uart_tx: RTL and testbench

Downstream consumer of the PRNG byte stream (the muxed 8-bit random value that also drives the two 7-segment digits). It buffers random bytes in a small FIFO and serialises them as 8N1 UART frames on a single output pin, so the sequence can be logged by a host. The block sits next to the HEX decoders in the top level. Its tx output is intended for one spare uio_out bit.

---
 rtl/prng_uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_prng_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/prng_uart_tx.sv
// PRNG byte logger: FIFO-buffered 8N1 UART transmitter for the random byte stream.
// Optional even-parity bit (8E1) when PRNG_UART_PARITY_EN is defined.
module prng_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               EN,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]    BAUD_LAST_C = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_C      = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PRNG_UART_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

`ifdef PRNG_UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t             state_r, state_s;
  logic [BW-1:0]      baud_r, baud_s;
  logic [2:0]         bit_r, bit_s;
  logic [7:0]         shift_r, shift_s;
  logic               tx_r, tx_s;
  logic [FIFO_AW:0]   count_r, count_s;
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [7:0]         mem_r [2**FIFO_AW];
  logic               overflow_r;
  logic               full_s, push_s, pop_s, launch_s, baud_done_s;
`ifdef PRNG_UART_PARITY_EN
  logic               parity_r, parity_s;
`endif

  assign full_s      = (count_r == FULL_C);
  assign push_s      = in_valid && !full_s;
  assign launch_s    = EN && (count_r != {(FIFO_AW+1){1'b0}});
  assign baud_done_s = (baud_r == BAUD_LAST_C);

  assign in_ready   = !full_s;
  assign tx         = tx_r;
  assign busy       = (state_r != IDLE);
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

  // FIFO occupancy update; pop never exceeds count since launch requires count != 0
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + (FIFO_AW+1)'(1'b1);
      2'b01:   count_s = count_r - (FIFO_AW+1)'(1'b1);
      default: count_s = count_r;
    endcase
  end

  // Frame sequencer: next state, baud/bit counters, shift register and next tx level
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
`ifdef PRNG_UART_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (launch_s) begin
          pop_s   = 1'b1;
          state_s = START;
          baud_s  = {BW{1'b0}};
          shift_s = mem_r[rd_ptr_r];
`ifdef PRNG_UART_PARITY_EN
          parity_s = even_parity(mem_r[rd_ptr_r]);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_done_s) begin
          state_s = DATA;
          baud_s  = {BW{1'b0}};
          bit_s   = 3'd0;
        end else begin
          baud_s = baud_r + BW'(1'b1);
        end
      end
      DATA: begin
        if (baud_done_s) begin
          baud_s  = {BW{1'b0}};
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
`ifdef PRNG_UART_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BW'(1'b1);
        end
      end
`ifdef PRNG_UART_PARITY_EN
      PARITY: begin
        if (baud_done_s) begin
          state_s = STOP;
          baud_s  = {BW{1'b0}};
        end else begin
          baud_s = baud_r + BW'(1'b1);
        end
      end
`endif
      STOP: begin
        if (baud_done_s) begin
          baud_s = {BW{1'b0}};
          // back-to-back frames: launch straight from the last stop cycle
          if (launch_s) begin
            pop_s   = 1'b1;
            state_s = START;
            shift_s = mem_r[rd_ptr_r];
`ifdef PRNG_UART_PARITY_EN
            parity_s = even_parity(mem_r[rd_ptr_r]);
`endif
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BW'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = {BW{1'b0}};
      end
    endcase

    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef PRNG_UART_PARITY_EN
      PARITY:  tx_s = parity_s;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // Sequencer and FIFO control registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      baud_r     <= {BW{1'b0}};
      bit_r      <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      count_r    <= {(FIFO_AW+1){1'b0}};
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      count_r <= count_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
      if (in_valid && full_s) overflow_r <= 1'b1;
    end
  end

`ifdef PRNG_UART_PARITY_EN
  // Parity of the byte currently being sent, captured at pop
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) parity_r <= 1'b0;
    else       parity_r <= parity_s;
  end
`endif

  // FIFO storage; contents need no reset
  always_ff @(posedge CLK) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data;
  end

endmodule

// File: tb/tb_prng_uart_tx.sv
// Randomised and directed bench for prng_uart_tx against a frame-timeline reference model.
module tb_prng_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef PRNG_UART_PARITY_EN
  localparam int FRAME_C = 11 * CPB;
`else
  localparam int FRAME_C = 10 * CPB;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        EN = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, tx, busy, overflow;
  logic [AW:0] fifo_count;

  prng_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .CLK(CLK), .reset(reset), .EN(EN), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cycles = 0;

  // reference model: queued bytes, cycles left in the current frame, byte on the line
  logic [7:0] m_q[$];
  int         m_left = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic model_tx(input int left, input logic [7:0] b);
    int idx;
    if (left == 0) return 1'b1;
    idx = (FRAME_C - left) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef PRNG_UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_left = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge();
    int sz;
    if (reset) begin
      model_reset();
    end else begin
      sz = m_q.size();
      if (m_left <= 1 && EN && sz > 0) begin
        m_byte = m_q.pop_front();
        m_left = FRAME_C;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (in_valid) begin
        if (sz < DEPTH) m_q.push_back(in_data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("tx", 32'(tx), 32'(model_tx(m_left, m_byte)));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    if (busy) busy_cycles++;
    check_outputs();
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_tx"}, 32'(tx), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    busy_cycles = 0;
  endtask

  task automatic push_one(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;

    // 1: scramble state with random traffic, then reset mid-frame
    EN = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      cycle();
    end
    async_reset_check("t1");

    // 2: single 0xA5 frame
    EN = 1'b1;
    push_one(8'hA5);
    chk("t2_tx_accept_edge", 32'(tx), 32'd1);
    cycle();
    chk("t2_start_bit", 32'(tx), 32'd0);
    repeat (FRAME_C + 5) cycle();
    chk("t2_frame_len", 32'(busy_cycles), 32'(FRAME_C));

    // 3: six-byte burst into a four-entry FIFO
    async_reset_check("t3_rst");
    EN = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    chk("t3_count_full", 32'(fifo_count), 32'd4);
    chk("t3_in_ready_low", 32'(in_ready), 32'd0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    repeat (5 * FRAME_C + 10) cycle();
    chk("t3_busy_total", 32'(busy_cycles), 32'(5 * FRAME_C));
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: EN dropped mid-frame with two bytes queued
    async_reset_check("t4_rst");
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (10) cycle();
    EN = 1'b0;
    repeat (FRAME_C + 10) cycle();
    chk("t4_hold_count", 32'(fifo_count), 32'd2);
    chk("t4_hold_tx", 32'(tx), 32'd1);
    chk("t4_hold_busy", 32'(busy), 32'd0);
    EN = 1'b1;
    cycle();
    chk("t4_restart", 32'(tx), 32'd0);
    repeat (2 * FRAME_C + 5) cycle();

    // 5: reset during data bit 3, then line stays idle
    async_reset_check("t5_pre");
    EN = 1'b1;
    push_one(8'hF0);
    repeat (1 + CPB + 3 * CPB + 1) cycle();
    async_reset_check("t5");
    repeat (60) cycle();
    chk("t5_idle_tx", 32'(tx), 32'd1);

    // 6: 0x07 frame, bit position 9 and frame length
    push_one(8'h07);
    cycle();
    repeat (9 * CPB + 1) cycle();
    chk("t6_bit9", 32'(tx), 32'd1);
    repeat (FRAME_C) cycle();
    chk("t6_frame_len", 32'(busy_cycles), 32'(FRAME_C));

    // random traffic with random EN gaps
    for (int i = 0; i < 2000; i++) begin
      in_valid = ($urandom_range(0, 5) == 0);
      in_data  = 8'($urandom);
      EN       = ($urandom_range(0, 15) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
